// File: rtl/axil_pkg.sv
// Shared AXI4-lite types for the RAM slave and the core's master side.
// Response codes used on the B and R channels.
package axil_pkg;

  typedef enum logic [1:0] {
    AXIL_OKAY   = 2'b00,
    AXIL_SLVERR = 2'b10
  } axil_resp_t;

endpackage

// File: rtl/axil_ram_if.sv
// AXI4-lite bus bundle between the memory master and axil_ram.
// master modport drives requests, slave modport drives responses.
interface axil_ram_if
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  axil_resp_t            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  axil_resp_t            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid,
    output bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid,
    input  bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_ram_mem.sv
// DEPTH x DATA_WIDTH synchronous RAM, byte-enabled write port,
// registered read port; read-first on same-word collisions.
module axil_ram_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [STRB_WIDTH-1:0] be,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] ram [DEPTH];

  // Non-blocking update makes a same-edge read see the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (be[i]) ram[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) q <= ram[raddr];
  end

endmodule

// File: rtl/axil_ram.sv
// AXI4-lite RAM slave: decode, B/R response regs, RAM instance.
// Define AXIL_RAM_RD_PIPE_EN for a 2-cycle registered read path.
module axil_ram
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic        clk,
  input  logic        rst,
  axil_ram_if.slave   axi
);

  localparam int LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] SPAN =
    (ADDR_WIDTH+1)'(DEPTH * STRB_WIDTH);

  logic [ADDR_WIDTH-1:0] w_off;
  logic [ADDR_WIDTH-1:0] r_off;
  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W-1:0]      r_idx;
  logic                  w_hit;
  logic                  r_hit;
  logic                  w_acc;
  logic                  r_acc;
  logic                  ar_ready;
  logic [DATA_WIDTH-1:0] q;

  logic                  b_valid;
  axil_resp_t            b_resp;
  logic                  r_valid;
  axil_resp_t            r_resp;

  // Offsets below BASE_ADDR wrap to large values and miss.
  assign w_off = axi.awaddr - BASE_ADDR;
  assign r_off = axi.araddr - BASE_ADDR;
  assign w_hit = {1'b0, w_off} < SPAN;
  assign r_hit = {1'b0, r_off} < SPAN;
  assign w_idx = w_off[LSB +: IDX_W];
  assign r_idx = r_off[LSB +: IDX_W];

  assign w_acc = axi.awvalid & axi.wvalid
               & (~b_valid | axi.bready);
  assign r_acc = axi.arvalid & ar_ready;

  assign axi.awready = w_acc;
  assign axi.wready  = w_acc;
  assign axi.arready = ar_ready;
  assign axi.bvalid  = b_valid;
  assign axi.bresp   = b_resp;
  assign axi.rvalid  = r_valid;
  assign axi.rresp   = r_resp;

  axil_ram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_acc & w_hit),
    .be    (axi.wstrb),
    .waddr (w_idx),
    .wdata (axi.wdata),
    .re    (r_acc),
    .raddr (r_idx),
    .q     (q)
  );

  // Write response: load on accept, hold until bready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_valid <= 1'b0;
      b_resp  <= AXIL_OKAY;
    end else if (w_acc) begin
      b_valid <= 1'b1;
      b_resp  <= w_hit ? AXIL_OKAY : AXIL_SLVERR;
    end else if (axi.bready) begin
      b_valid <= 1'b0;
    end
  end

`ifdef AXIL_RAM_RD_PIPE_EN

  logic                  s1_val;
  logic                  s1_hit;
  logic                  s2_adv;
  logic [DATA_WIDTH-1:0] r_data;

  // s1 may only be refilled when it is empty or moving into s2.
  assign s2_adv   = ~r_valid | axi.rready;
  assign ar_ready = ~(s1_val & ~s2_adv);
  assign axi.rdata = r_data;

  // Stage 1 tracks the word sitting on the RAM output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_val <= 1'b0;
      s1_hit <= 1'b0;
    end else if (r_acc) begin
      s1_val <= 1'b1;
      s1_hit <= r_hit;
    end else if (s2_adv) begin
      s1_val <= 1'b0;
    end
  end

  // Stage 2 is the R channel register, held under rready stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_resp  <= AXIL_OKAY;
    end else if (s2_adv) begin
      r_valid <= s1_val;
      if (s1_val) begin
        r_data <= s1_hit ? q : '0;
        r_resp <= s1_hit ? AXIL_OKAY : AXIL_SLVERR;
      end
    end
  end

`else

  logic r_ok;

  // RAM output only changes on accept, so it doubles as rdata.
  assign ar_ready  = ~r_valid | axi.rready;
  assign axi.rdata = r_ok ? q : '0;

  // Read response: load on accept, hold until rready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ok    <= 1'b0;
      r_resp  <= AXIL_OKAY;
    end else if (r_acc) begin
      r_valid <= 1'b1;
      r_ok    <= r_hit;
      r_resp  <= r_hit ? AXIL_OKAY : AXIL_SLVERR;
    end else if (axi.rready) begin
      r_valid <= 1'b0;
    end
  end

`endif

endmodule
